// File: rtl/ble_iq_pkg.sv
// Shared types and helpers for the BLE IQ receive capture path.
// Holds the pairing FSM state encoding, the packed-half width, the
// sign-extension helper and the FIFO entry layout.
package ble_iq_pkg;

    // Width of each packed half of the output word.
    localparam int PACK_W = 16;

    // Pairing FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_RE = 2'd1,
        HOLD_IM = 2'd2
    } ble_iq_state_t;

    // One FIFO entry: frame-close flag plus the packed IQ word.
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } ble_iq_entry_t;

    // Sign-extend the low w bits of val to PACK_W bits (1 <= w <= PACK_W).
    function automatic logic [PACK_W-1:0] sext16(input logic [PACK_W-1:0] val,
                                                 input int                w);
        logic [PACK_W-1:0] res;
        res = val;
        for (int i = 0; i < PACK_W; i++) begin
            if (i >= w) begin
                res[i] = val[w-1];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ble_iq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO of ble_iq_entry_t words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write into a full FIFO is accepted only if a read happens on the same
// edge; a read from an empty FIFO is ignored; clear wins over both.
// The head entry reads as zero while the FIFO is empty.
module ble_iq_sync_fifo
    import ble_iq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  ble_iq_entry_t            i_wr_entry,
    input  logic                     i_rd_en,
    output ble_iq_entry_t            o_rd_entry,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    ble_iq_entry_t r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_wr;
    logic          w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_do_rd = i_rd_en && !o_empty && !i_clear;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd) && !i_clear;

    assign o_rd_entry = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: written at the tail on every accepted push.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_entry;
        end
    end

    // Read/write pointers with wrap bit; clear empties the FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ble_iq_rx_capture.sv
// BLE baseband IQ receive capture.
// Re-pairs independently-valid real/imaginary samples (bounded skew),
// packs each pair into {sext16(re), sext16(im)}, tags frame ends and
// buffers words in a FWFT FIFO toward the local RX memory path.
// Optional statistics counters: define BLE_IQ_RX_CAPTURE_STATS_EN.
//
// Output handshake: out_valid is high whenever the FIFO holds a word and
// out_data/out_last show that head word; the word is consumed on a rising
// edge where out_valid and out_ready are both high, and out_ready may be
// asserted independently of out_valid.
module ble_iq_rx_capture
    import ble_iq_pkg::*;
#(
    parameter int RE_IM_SIZE_BLE = 12,
    parameter int DEPTH_BLE      = 16,
    parameter int WIDTH_BLE      = 32,
    parameter int SKEW_MAX       = 2
) (
    input  logic                          phy_ble_clk,
    input  logic                          RESET,
    input  logic                          valid_in_mem_re_ble,
    input  logic [RE_IM_SIZE_BLE-1:0]     data_in_re_to_rx_ble,
    input  logic                          valid_in_mem_im_ble,
    input  logic [RE_IM_SIZE_BLE-1:0]     data_in_im_to_rx_ble,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [15:0]                   frame_len,
    output logic                          out_valid,
    output logic [WIDTH_BLE-1:0]          out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH_BLE):0]    level,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          skew_err,
    output logic [31:0]                   pair_count,
    output logic [15:0]                   drop_count,
    output logic [1:0]                    o_dbg_state
);

    // Wait counter must be able to hold SKEW_MAX-1 (SKEW_MAX >= 1).
    localparam int WAIT_W = (SKEW_MAX < 2) ? 1 : $clog2(SKEW_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(SKEW_MAX - 1);

    // Pairing state
    ble_iq_state_t             r_state;
    ble_iq_state_t             w_state_nxt;
    logic [RE_IM_SIZE_BLE-1:0] r_hold;
    logic [RE_IM_SIZE_BLE-1:0] w_hold_nxt;
    logic [WAIT_W-1:0]         r_wait;
    logic [WAIT_W-1:0]         w_wait_nxt;
    logic                      w_pair_valid;
    logic [RE_IM_SIZE_BLE-1:0] w_pair_re;
    logic [RE_IM_SIZE_BLE-1:0] w_pair_im;
    logic                      w_skew_drop;

    // Pack register, framing and flags
    logic                      r_pack_valid;
    logic [31:0]               r_pack_data;
    logic [15:0]               r_frame_cnt;
    logic                      r_frame_done;
    logic                      r_overflow;
    logic                      r_skew_err;

    // FIFO interface
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_fifo_wr;
    logic                      w_pop;
    logic                      w_push_ok;
    logic                      w_drop_ovf;
    logic                      w_push_last;
    logic                      w_skew_ev;
    logic [16:0]               w_frame_cnt_inc;
    ble_iq_entry_t             w_wr_entry;
    ble_iq_entry_t             w_rd_entry;

    // Pairing next-state: match re with im, tolerate up to SKEW_MAX cycles of lag.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_wait_nxt   = r_wait;
        w_pair_valid = 1'b0;
        w_pair_re    = '0;
        w_pair_im    = '0;
        w_skew_drop  = 1'b0;
        if (!enable) begin
            // Disabled: drop anything held silently and park in IDLE.
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in_mem_re_ble && valid_in_mem_im_ble) begin
                        w_pair_valid = 1'b1;
                        w_pair_re    = data_in_re_to_rx_ble;
                        w_pair_im    = data_in_im_to_rx_ble;
                    end else if (valid_in_mem_re_ble) begin
                        w_hold_nxt  = data_in_re_to_rx_ble;
                        w_wait_nxt  = '0;
                        w_state_nxt = HOLD_RE;
                    end else if (valid_in_mem_im_ble) begin
                        w_hold_nxt  = data_in_im_to_rx_ble;
                        w_wait_nxt  = '0;
                        w_state_nxt = HOLD_IM;
                    end
                end
                HOLD_RE: begin
                    if (valid_in_mem_im_ble) begin
                        w_pair_valid = 1'b1;
                        w_pair_re    = r_hold;
                        w_pair_im    = data_in_im_to_rx_ble;
                        if (valid_in_mem_re_ble) begin
                            w_hold_nxt = data_in_re_to_rx_ble;
                            w_wait_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (valid_in_mem_re_ble) begin
                        w_hold_nxt  = data_in_re_to_rx_ble;
                        w_wait_nxt  = '0;
                        w_skew_drop = 1'b1;
                    end else if (r_wait == WAIT_LIMIT) begin
                        w_skew_drop = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                end
                HOLD_IM: begin
                    if (valid_in_mem_re_ble) begin
                        w_pair_valid = 1'b1;
                        w_pair_re    = data_in_re_to_rx_ble;
                        w_pair_im    = r_hold;
                        if (valid_in_mem_im_ble) begin
                            w_hold_nxt = data_in_im_to_rx_ble;
                            w_wait_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (valid_in_mem_im_ble) begin
                        w_hold_nxt  = data_in_im_to_rx_ble;
                        w_wait_nxt  = '0;
                        w_skew_drop = 1'b1;
                    end else if (r_wait == WAIT_LIMIT) begin
                        w_skew_drop = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = '0;
                end
            endcase
        end
    end

    // Pairing state register; clear returns to IDLE and forgets any held sample.
    always_ff @(posedge phy_ble_clk or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_wait  <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Pack register: sign-extend both halves one cycle ahead of the FIFO write.
    always_ff @(posedge phy_ble_clk or posedge RESET) begin
        if (RESET) begin
            r_pack_valid <= 1'b0;
            r_pack_data  <= '0;
        end else if (clear) begin
            r_pack_valid <= 1'b0;
        end else begin
            r_pack_valid <= w_pair_valid;
            if (w_pair_valid) begin
                r_pack_data <= {sext16(PACK_W'(w_pair_re), RE_IM_SIZE_BLE),
                                sext16(PACK_W'(w_pair_im), RE_IM_SIZE_BLE)};
            end
        end
    end

    assign w_pop           = out_ready && !w_fifo_empty;
    assign w_fifo_wr       = r_pack_valid && !clear;
    assign w_drop_ovf      = w_fifo_wr && w_fifo_full && !w_pop;
    assign w_push_ok       = w_fifo_wr && !w_drop_ovf;
    assign w_skew_ev       = w_skew_drop && !clear;
    assign w_frame_cnt_inc = {1'b0, r_frame_cnt} + 17'd1;
    assign w_push_last     = (frame_len != 16'd0) &&
                             (w_frame_cnt_inc >= {1'b0, frame_len});
    assign w_wr_entry      = '{last: w_push_last, data: r_pack_data};

    // Frame counter and frame_done pulse; only accepted pushes advance the frame.
    always_ff @(posedge phy_ble_clk or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_push_ok && w_push_last;
            if (w_push_ok) begin
                r_frame_cnt <= w_push_last ? 16'd0 : w_frame_cnt_inc[15:0];
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge phy_ble_clk or posedge RESET) begin
        if (RESET) begin
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (w_drop_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_skew_ev) begin
                r_skew_err <= 1'b1;
            end
        end
    end

    ble_iq_sync_fifo #(
        .DEPTH (DEPTH_BLE)
    ) u_fifo (
        .i_clk      (phy_ble_clk),
        .i_rst      (RESET),
        .i_clear    (clear),
        .i_wr_en    (w_fifo_wr),
        .i_wr_entry (w_wr_entry),
        .i_rd_en    (out_ready),
        .o_rd_entry (w_rd_entry),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (level)
    );

    assign out_valid   = !w_fifo_empty;
    assign out_data    = w_rd_entry.data;
    assign out_last    = w_rd_entry.last;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign skew_err    = r_skew_err;
    assign o_dbg_state = r_state;

`ifdef BLE_IQ_RX_CAPTURE_STATS_EN
    logic [31:0] r_pair_count;
    logic [15:0] r_drop_count;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + {16'd0, w_drop_ovf} + {16'd0, w_skew_ev};

    // Statistics: accepted pushes (wrapping) and drops (saturating).
    always_ff @(posedge phy_ble_clk or posedge RESET) begin
        if (RESET) begin
            r_pair_count <= '0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_pair_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_pair_count <= r_pair_count + 32'd1;
            end
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign pair_count = r_pair_count;
    assign drop_count = r_drop_count;
`else
    assign pair_count = 32'd0;
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_ble_iq_rx_capture.sv
// Bench for ble_iq_rx_capture: directed stimulus, expected words queued at
// issue time and checked by an independent output monitor.
module tb_ble_iq_rx_capture;
    import ble_iq_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_re;
    logic [11:0] data_re;
    logic        valid_im;
    logic [11:0] data_im;
    logic        enable;
    logic        clear;
    logic [15:0] frame_len;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [4:0]  level;
    logic        frame_done;
    logic        overflow;
    logic        skew_err;
    logic [31:0] pair_count;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;

    logic [32:0] exp_q[$];
    int          errors;
    int          checks;
    int          fd_cnt;

    ble_iq_rx_capture dut (
        .phy_ble_clk          (clk),
        .RESET                (rst),
        .valid_in_mem_re_ble  (valid_re),
        .data_in_re_to_rx_ble (data_re),
        .valid_in_mem_im_ble  (valid_im),
        .data_in_im_to_rx_ble (data_im),
        .enable               (enable),
        .clear                (clear),
        .frame_len            (frame_len),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .out_last             (out_last),
        .out_ready            (out_ready),
        .level                (level),
        .frame_done           (frame_done),
        .overflow             (overflow),
        .skew_err             (skew_err),
        .pair_count           (pair_count),
        .drop_count           (drop_count),
        .o_dbg_state          (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops and compares against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got last=%0d data=0x%08h with no word expected",
                         out_last, out_data);
            end else begin
                logic [32:0] want;
                want = exp_q.pop_front();
                if ({out_last, out_data} !== want) begin
                    errors++;
                    $display("FAIL out_word: got last=%0d data=0x%08h expected last=%0d data=0x%08h",
                             out_last, out_data, want[32], want[31:0]);
                end
            end
        end
        if (!rst && frame_done) fd_cnt++;
    end

    function automatic logic [15:0] sx(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    // Drive one cycle of sample inputs, then return just after the edge.
    task automatic cyc(input logic rv, input logic [11:0] r, input logic iv, input logic [11:0] im);
        valid_re = rv;
        data_re  = r;
        valid_im = iv;
        data_im  = im;
        @(posedge clk);
        #1;
        valid_re = 1'b0;
        valid_im = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 12'h0, 1'b0, 12'h0);
    endtask

    // Simultaneous pair; expected word optionally queued.
    task automatic pair(input logic [11:0] r, input logic [11:0] im, input logic last, input logic push);
        if (push) exp_q.push_back({last, sx(r), sx(im)});
        cyc(1'b1, r, 1'b1, im);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; fd_cnt = 0;
        rst = 1'b1; valid_re = 0; data_re = 0; valid_im = 0; data_im = 0;
        enable = 1'b1; clear = 1'b0; frame_len = 16'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_flags", {frame_done, overflow, skew_err, out_last}, 0);
        chk("rst_counts", {pair_count, drop_count}, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        idle(1);

        // Simultaneous pair, max positive re / max negative-ish im
        exp_q.push_back({1'b0, 32'h07FF_F801});
        cyc(1'b1, 12'h7FF, 1'b1, 12'h801);
        idle(1);
        chk("t1_level", level, 1);
        chk("t1_out_data", out_data, 32'h07FF_F801);
        chk("t1_out_last", out_last, 0);
        out_ready = 1'b1;
        idle(2);
        chk("t1_drained", level, 0);

        // re then im one cycle later
        exp_q.push_back({1'b0, 32'h0123_0005});
        cyc(1'b1, 12'h123, 1'b0, 12'h0);
        cyc(1'b0, 12'h0, 1'b1, 12'h005);
        // im then re one cycle later
        exp_q.push_back({1'b0, 32'h0001_F800});
        cyc(1'b0, 12'h0, 1'b1, 12'h800);
        cyc(1'b1, 12'h001, 1'b0, 12'h0);
        idle(3);
        chk("t2_no_skew", skew_err, 0);
        // re alone, partner never arrives
        cyc(1'b1, 12'h055, 1'b0, 12'h0);
        idle(3);
        chk("t2_skew_err", skew_err, 1);
        chk("t2_state_idle", dbg_state, IDLE);
        chk("t2_no_word", level, 0);
`ifdef BLE_IQ_RX_CAPTURE_STATS_EN
        chk("t2_drop_count", drop_count, 1);
`else
        chk("t2_drop_count", drop_count, 0);
`endif
        pulse_clear();
        chk("t2_clear_skew", skew_err, 0);
        // held re replaced before im arrives
        exp_q.push_back({1'b0, 32'h0222_0333});
        cyc(1'b1, 12'h111, 1'b0, 12'h0);
        cyc(1'b1, 12'h222, 1'b0, 12'h0);
        cyc(1'b0, 12'h0, 1'b1, 12'h333);
        idle(3);
        chk("t2_replace_skew", skew_err, 1);
        pulse_clear();
        // enable low discards held sample without flag
        cyc(1'b1, 12'h444, 1'b0, 12'h0);
        chk("t2_hold_re", dbg_state, HOLD_RE);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        chk("t2_en_idle", dbg_state, IDLE);
        chk("t2_en_noflag", skew_err, 0);

        // Framing: frame_len = 4, 10 then 2 more pairs
        pulse_clear();
        frame_len = 16'd4;
        fd_cnt = 0;
        for (int i = 0; i < 10; i++)
            pair(12'(i + 1), 12'hFFF - 12'(i), (i == 3) || (i == 7), 1'b1);
        idle(4);
        chk("t3_frame_done_2", fd_cnt, 2);
        for (int i = 10; i < 12; i++)
            pair(12'(i + 1), 12'hFFF - 12'(i), i == 11, 1'b1);
        idle(4);
        chk("t3_frame_done_3", fd_cnt, 3);
`ifdef BLE_IQ_RX_CAPTURE_STATS_EN
        chk("t3_pair_count", pair_count, 12);
`else
        chk("t3_pair_count", pair_count, 0);
`endif

        // Overflow: 18 pairs into 16 entries with no consumer
        frame_len = 16'd0;
        pulse_clear();
        out_ready = 1'b0;
        for (int j = 0; j < 18; j++)
            pair(12'h100 + 12'(j), 12'hF00 + 12'(j), 1'b0, j < 16);
        idle(2);
        chk("t4_level_full", level, 16);
        chk("t4_overflow", overflow, 1);
`ifdef BLE_IQ_RX_CAPTURE_STATS_EN
        chk("t4_drop_count", drop_count, 2);
`else
        chk("t4_drop_count", drop_count, 0);
`endif
        out_ready = 1'b1;
        idle(20);
        chk("t4_drained", level, 0);

        // Full FIFO, push and pop on the same edge
        pulse_clear();
        out_ready = 1'b0;
        for (int j = 0; j < 16; j++)
            pair(12'h200 + 12'(j), 12'h010 + 12'(j), 1'b0, 1'b1);
        idle(2);
        chk("t5_level_full", level, 16);
        pair(12'h7AB, 12'h8CD, 1'b0, 1'b1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("t5_level_same", level, 16);
        chk("t5_no_overflow", overflow, 0);
        out_ready = 1'b1;
        idle(20);
        chk("t5_drained", level, 0);

        // Asynchronous reset mid-frame while holding an im sample
        frame_len = 16'd4;
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++)
            pair(12'h300 + 12'(j), 12'h003, 1'b0, 1'b1);
        idle(2);
        cyc(1'b0, 12'h0, 1'b1, 12'h003);
        chk("t6_level5", level, 5);
        chk("t6_hold_im", dbg_state, HOLD_IM);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_data", {out_last, out_data}, 0);
        chk("t6_rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        fd_cnt = 0;
        for (int j = 0; j < 4; j++)
            pair(12'h400 + 12'(j), 12'h004, j == 3, 1'b1);
        idle(4);
        chk("t6_new_frame", fd_cnt, 1);

        // clear during a push discards the in-flight pair
        frame_len = 16'd0;
        out_ready = 1'b0;
        pair(12'h0AA, 12'h0BB, 1'b0, 1'b0);
        clear = 1'b1;
        pair(12'h0CC, 12'h0DD, 1'b0, 1'b0);
        clear = 1'b0;
        idle(2);
        chk("t7_clear_level", level, 0);
        chk("t7_clear_valid", out_valid, 0);
        out_ready = 1'b1;
        pair(12'h765, 12'h89A, 1'b0, 1'b1);
        idle(3);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
